cpu_trace_buffer: RTL and testbench
===================================

# cpu_trace_buffer

- Captures one trace record per instruction retired by the multi-cycle CPU.
- Sits directly downstream of the debug signal aggregator and consumes its execution-state, macro-op, ALU-function, destination-register, write-mode and ALU-result fields.
- Records are stored in a DEPTH-entry FIFO and drained by a debug host over a valid/ready read port.
- Capture can be paused; on overflow, new records are dropped and a sticky flag is raised.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- ADDR_W, $clog2(DEPTH), pointer width.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- arm  input  1  level; 1 enables capture.
- clear  input  1  synchronous flush of FIFO, overflow flag and timestamp.
- exec_state  input  4  EXECUTION_STATES encoding (INIT=0 … WRITE_BACK=9).
- macro_op  input  3  MACRO_OPERATIONS encoding.
- alu_func  input  4  ALU_FUNCTIONS encoding.
- dst_reg  input  5  OPERANDS encoding.
- reg_wr  input  2  REG_WRITE_MODE encoding.
- alu_out  input  16  ALU result.
- rd_ready  input  1  host accepts rd_data.
- rd_valid  output  1  FIFO non-empty.
- rd_data  output  46  record at FIFO head: {stamp[45:30], alu_out[29:14], dst_reg[13:9], alu_func[8:5], macro_op[4:2], reg_wr[1:0]}.
- count  output  ADDR_W+1  occupied entries, 0..DEPTH.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- overflow  output  1  sticky; a capture was dropped.

## Operation
- prev_state register holds the previous cycle's exec_state. It resets to INIT (0).
- Capture event: arm=1 AND exec_state==WRITE_BACK AND prev_state!=WRITE_BACK.
  - This gives exactly one event per WRITE_BACK entry, independent of how long WRITE_BACK lasts.
  - prev_state updates every cycle regardless of arm.
- On a capture event:
  - Not full: the record is written at wr_ptr, and wr_ptr increments modulo DEPTH.
  - Full: the record is discarded and overflow is set to 1.
  - Full with a pop in the same cycle: the slot is freed, the capture is accepted, count stays at DEPTH, and overflow is unchanged.
- Pop: rd_valid AND rd_ready. rd_ptr increments modulo DEPTH.
- Simultaneous capture and pop on a non-empty FIFO: count is unchanged and both pointers advance.
- Pop while empty has no effect.
- rd_data is first-word-fall-through: combinational read of mem[rd_ptr] when non-empty; forced to 0 when empty.
- Timestamp: 16-bit free-running counter, +1 every cycle, wraps 0xFFFF→0x0000. The record stores the counter value of the capture cycle.
- clear=1 forces the following, and has priority over capture and pop in the same cycle:
  - pointers and count to 0;
  - overflow to 0;
  - timestamp to 0.
  - prev_state still updates, so an event cannot retrigger on the following cycle.
- Memory contents are not reset; emptiness is defined by count alone.

## Timing
- Reset values: rd_valid 0, rd_data 0, count 0, empty 1, full 0, overflow 0, timestamp 0, pointers 0, prev_state INIT.
- Capture latency: event in cycle N → rd_valid=1, count incremented and the record visible on rd_data in cycle N+1.
- Pop accepted at the edge ending cycle N → next record, or rd_valid=0, in cycle N+1.
- The fastest possible back-to-back capture is every 2 cycles (WRITE_BACK, then non-WRITE_BACK, then WRITE_BACK). The FIFO accepts every such event when not full.
- rst asserted mid-operation:
  - All registers take their reset values immediately (asynchronously).
  - Any in-flight record is lost.
  - The first capture after deassertion requires a fresh entry into WRITE_BACK.
- full, empty and count are registered-derived; they carry no combinational path from inputs.

## Configuration
- Macro TRACE_TIMESTAMP_EN.
- Defined: the timestamp counter is instantiated and stamp[45:30] carries the capture cycle value.
- Undefined: no counter is built, stamp[45:30] is constant 0, and clear affects only the FIFO and overflow. All other behaviour is identical.

## Test plan
- Reset, then arm=1 and exec_state sequence FETCH,DECODE,ALU_EXECUTE,WRITE_BACK,WRITE_BACK,FETCH → exactly one record, count=1, rd_data reg_wr/dst_reg/alu_out match inputs.
- TRACE_TIMESTAMP_EN defined: capture at cycle 5 and cycle 9 after reset release → stamps 5 and 9. Undefined → stamps 0.
- DEPTH=16: 17 WRITE_BACK entries with rd_ready=0 → full=1, count=16, overflow=1, and drained records 1..16 in order (record 17 absent).
- FIFO full with capture and pop in the same cycle → count stays 16, overflow stays 0, and the new record is last out.
- arm=0 during 3 WRITE_BACK entries → count 0. clear asserted together with a capture event → count 0, overflow 0, stamp restarts at 0.
- Assert rst while count=5 and an event is pending → all outputs at reset values next sample. After release, the first WRITE_BACK produces a record stamped from 0.

Source files
------------

// File: rtl/cpu_trace_buffer.sv
// Trace FIFO capturing one record per WRITE_BACK entry, drained over valid/ready.
// Define TRACE_TIMESTAMP_EN to build the capture-cycle timestamp counter.
module cpu_trace_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arm,
    input  logic              clear,
    input  logic [3:0]        exec_state,
    input  logic [2:0]        macro_op,
    input  logic [3:0]        alu_func,
    input  logic [4:0]        dst_reg,
    input  logic [1:0]        reg_wr,
    input  logic [15:0]       alu_out,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [45:0]       rd_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    localparam logic [3:0]      WRITE_BACK = 4'd9;
    localparam logic [ADDR_W:0] DEPTH_CNT  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_CNT    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] ONE_PTR  = ADDR_W'(1);

    logic [45:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;
    logic [3:0]        prev_state;
    logic              ovf;
    logic [15:0]       stamp;
    logic              cap;
    logic              pop;
    logic              push;
    logic              drop;
    logic              is_full;
    logic              is_empty;
    logic [45:0]       rec;

    // A full FIFO still accepts a capture when the same cycle frees a slot.
    always_comb begin
        is_full  = (cnt == DEPTH_CNT);
        is_empty = (cnt == '0);
        cap      = arm && (exec_state == WRITE_BACK) && (prev_state != WRITE_BACK);
        pop      = !is_empty && rd_ready;
        push     = cap && (!is_full || pop);
        drop     = cap && is_full && !pop;
        rec      = {stamp, alu_out, dst_reg, alu_func, macro_op, reg_wr};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_state <= '0;
        end else begin
            prev_state <= exec_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ONE_PTR;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ONE_PTR;
            end
            if (push && !pop) begin
                cnt <= cnt + ONE_CNT;
            end else if (pop && !push) begin
                cnt <= cnt - ONE_CNT;
            end
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

    // Storage is never reset; occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= rec;
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stamp <= '0;
        end else if (clear) begin
            stamp <= '0;
        end else begin
            stamp <= stamp + 16'd1;
        end
    end
`else
    assign stamp = '0;
`endif

    assign rd_valid = !is_empty;
    assign rd_data  = is_empty ? '0 : mem[rd_ptr];
    assign count    = cnt;
    assign full     = is_full;
    assign empty    = is_empty;
    assign overflow = ovf;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Scoreboard bench for cpu_trace_buffer: directed captures, overflow, clear, reset.
// Expected stamps follow TRACE_TIMESTAMP_EN the same way the design does.
module tb_cpu_trace_buffer;

    localparam logic [3:0] FETCH = 4'd1;
    localparam logic [3:0] DECODE = 4'd2;
    localparam logic [3:0] EXEC = 4'd4;
    localparam logic [3:0] WB = 4'd9;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm;
    logic        clear;
    logic [3:0]  exec_state;
    logic [2:0]  macro_op;
    logic [3:0]  alu_func;
    logic [4:0]  dst_reg;
    logic [1:0]  reg_wr;
    logic [15:0] alu_out;
    logic        rd_ready;
    logic        rd_valid;
    logic [45:0] rd_data;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] cyc;
    logic [45:0] sb [$];

    cpu_trace_buffer #(.DEPTH(16)) dut (
        .clk(clk), .rst(rst), .arm(arm), .clear(clear),
        .exec_state(exec_state), .macro_op(macro_op),
        .alu_func(alu_func), .dst_reg(dst_reg), .reg_wr(reg_wr),
        .alu_out(alu_out), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .rd_data(rd_data), .count(count), .full(full),
        .empty(empty), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted read must match the oldest expected record.
    always @(negedge clk) begin
        logic [45:0] e;
        if (!rst && rd_valid && rd_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rd_pop: got record %0h expected none", rd_data);
            end else begin
                e = sb.pop_front();
                chk("rd_data", {18'd0, rd_data}, {18'd0, e});
            end
        end
    end

    task automatic set_fields(input int idx);
        alu_out  = 16'hA000 + 16'(idx);
        dst_reg  = 5'(idx);
        alu_func = 4'(idx + 3);
        macro_op = 3'(idx + 1);
        reg_wr   = 2'(idx);
    endtask

    function automatic logic [45:0] exp_rec(input logic [15:0] s);
`ifdef TRACE_TIMESTAMP_EN
        return {s, alu_out, dst_reg, alu_func, macro_op, reg_wr};
`else
        return {16'd0, alu_out, dst_reg, alu_func, macro_op, reg_wr};
`endif
    endfunction

    task automatic step(input logic [3:0] st, input logic rdy);
        exec_state = st;
        rd_ready   = rdy;
        @(posedge clk);
        #1;
        cyc = clear ? 16'd0 : cyc + 16'd1;
    endtask

    // One WRITE_BACK entry followed by a non-WRITE_BACK cycle.
    task automatic entry(input int idx, input bit keep, input logic rdy);
        set_fields(idx);
        if (keep) sb.push_back(exp_rec(cyc));
        step(WB, rdy);
        step(FETCH, 1'b0);
    endtask

    initial begin
        rst = 1'b1; arm = 1'b1; clear = 1'b0; rd_ready = 1'b0;
        exec_state = 4'd0; set_fields(0); cyc = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        rst = 1'b0;
        cyc = '0;

        // Single capture at cycle 5, long WRITE_BACK, second at cycle 9
        step(FETCH, 0); step(DECODE, 0); step(EXEC, 0);
        step(EXEC, 0); step(EXEC, 0);
        set_fields(1);
        sb.push_back(exp_rec(cyc));
        step(WB, 0);
        chk("lat_rd_valid", rd_valid, 1);
        chk("lat_count", count, 1);
        step(WB, 0); step(FETCH, 0);
        chk("one_record_count", count, 1);
        step(DECODE, 0);
        entry(2, 1, 0);
        chk("two_record_count", count, 2);
        step(FETCH, 1); step(FETCH, 1);
        chk("drain1_count", count, 0);
        chk("drain1_rd_valid", rd_valid, 0);
        chk("drain1_rd_data", rd_data, 0);

        // Fill, simultaneous capture+pop at full, then overflow drop
        clear = 1'b1; step(FETCH, 0); clear = 1'b0;
        for (int i = 0; i < 16; i++) entry(100 + i, 1, 0);
        chk("fill_full", full, 1);
        chk("fill_count", count, 16);
        chk("fill_overflow", overflow, 0);
        entry(116, 1, 1);
        chk("cap_pop_count", count, 16);
        chk("cap_pop_overflow", overflow, 0);
        entry(117, 0, 0);
        chk("ovf_flag", overflow, 1);
        chk("ovf_count", count, 16);
        repeat (16) step(FETCH, 1);
        chk("drain2_count", count, 0);
        chk("drain2_empty", empty, 1);
        chk("drain2_sb_left", sb.size(), 0);

        // Disarmed captures are ignored
        arm = 1'b0;
        for (int i = 0; i < 3; i++) entry(40 + i, 0, 0);
        chk("disarm_count", count, 0);
        chk("disarm_ovf_sticky", overflow, 1);
        arm = 1'b1;

        // Clear beats a simultaneous capture; no retrigger while in WB
        entry(20, 0, 0);
        chk("pre_clear_count", count, 1);
        set_fields(21);
        clear = 1'b1; step(WB, 0); clear = 1'b0;
        chk("clear_count", count, 0);
        chk("clear_overflow", overflow, 0);
        step(WB, 0);
        chk("no_retrigger", count, 0);
        step(FETCH, 0);
        entry(22, 1, 0);
        chk("post_clear_count", count, 1);
        step(FETCH, 1);
        chk("drain3_count", count, 0);

        // Asynchronous reset with entries held and an event pending
        for (int i = 0; i < 5; i++) entry(50 + i, 0, 0);
        chk("pre_rst_count", count, 5);
        set_fields(30);
        exec_state = WB;
        #2 rst = 1'b1;
        #1;
        chk("arst_rd_valid", rd_valid, 0);
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_rd_data", rd_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = '0;
        sb.push_back(exp_rec(cyc));
        step(WB, 0);
        step(FETCH, 0);
        chk("post_rst_count", count, 1);
        step(FETCH, 1);
        chk("final_count", count, 0);
        chk("final_sb_left", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
